gb_out_framer: RTL
==================

GB_OUT_FRAMER -- requirements
Module: gb_out_framer

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 480, output pixels per line (range 2..511).
REQ-003 SHALL have parameter IMG_H, default 640, output lines per frame (range 2..1023).
REQ-004 SHALL have port ap_clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port ap_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse arming one frame.
REQ-007 SHALL have port in_TDATA  input  PIX_W  filtered pixel from the Gaussian stage.
REQ-008 SHALL have port in_TVALID  input  1  upstream beat valid.
REQ-009 SHALL have port in_TREADY  output  1  beat accepted when in_TVALID & in_TREADY.
REQ-010 SHALL have port out_TDATA  output  PIX_W  framed pixel.
REQ-011 SHALL have port out_TVALID  output  1  downstream beat valid.
REQ-012 SHALL have port out_TREADY  input  1  downstream ready.
REQ-013 SHALL have port out_TLAST  output  1  high on last pixel of each line.
REQ-014 SHALL have port out_TUSER  output  1  high on first pixel of frame (SOF).
REQ-015 SHALL have port busy  output  1  high when FSM not IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse when the frame has fully left the block.

Function
REQ-017 SHALL implement FSM IDLE, RUN, DRAIN.
REQ-018 IDLE: in_TREADY=0; start -> RUN, x/y counters cleared same edge.
REQ-019 RUN: in_TREADY = ~fifo_full; each accepted beat increments x; x==IMG_W-1 -> x=0, y+1.
REQ-020 RUN: acceptance of pixel (IMG_W-1, IMG_H-1) -> DRAIN; in_TREADY=0 from next cycle.
REQ-021 DRAIN: fifo empty -> IDLE with done=1 for exactly that one cycle.
REQ-022 start while busy=1 SHALL be ignored (no counter or state effect).
REQ-023 Each accepted beat SHALL be pushed into a 2-entry FIFO as {data, last=(x==IMG_W-1), user=(x==0 & y==0)}.
REQ-024 out_TVALID = ~fifo_empty; out_TDATA/TLAST/TUSER = FIFO head; held stable while out_TVALID & ~out_TREADY.
REQ-025 Latency: beat accepted at edge N SHALL be presented on out_* at cycle N+1 at earliest; no combinational in->out path.
REQ-026 Sustained throughput SHALL be 1 beat/cycle while in_TVALID and out_TREADY stay high.
REQ-027 Simultaneous push and pop at occupancy 1 SHALL leave occupancy 1; at occupancy 2 no push occurs (in_TREADY=0).
REQ-028 Pop at occupancy 0 SHALL not occur; FIFO pointers wrap modulo 2.
REQ-029 Counters SHALL be $clog2(IMG_W) and $clog2(IMG_H) bits; no overflow past IMG_W-1/IMG_H-1.
REQ-030 in_TVALID in IDLE/DRAIN SHALL be back-pressured, never dropped or counted.

Reset
REQ-031 ap_rst_n=0 SHALL asynchronously force IDLE, FIFO empty, x=y=0.
REQ-032 Reset values: in_TREADY=0, out_TVALID=0, out_TDATA=0, out_TLAST=0, out_TUSER=0, busy=0, done=0.
REQ-033 Reset mid-frame SHALL discard FIFO contents and emit no done pulse.

Structure
REQ-034 Package gb_pkg SHALL hold the FSM state enum, PIX_W/IMG_W/IMG_H defaults and the FIFO entry typedef.
REQ-035 FIFO SHALL be sub-module gb_axis_fifo2 (2 entries, full/empty flags, data+last+user).

Verification (IMG_W=4, IMG_H=3)
REQ-036 start, in/out always valid/ready, pixels 0..11 -> out 0..11 contiguous, TUSER only on 0, TLAST on 3,7,11, done 1 cycle after pixel 11 leaves.
REQ-037 out_TREADY=0 for 5 cycles mid-frame -> in_TREADY low after 2 beats buffered, out_TDATA stable, no loss or duplication.
REQ-038 in_TVALID=1 with no start -> in_TREADY stays 0, out_TVALID stays 0 for 20 cycles.
REQ-039 second start pulse at pixel 5 -> ignored; frame ends normally after 12 beats, single done.
REQ-040 ap_rst_n low at pixel 6 -> all outputs 0 immediately; new start then produces full frame with TUSER on first beat.
REQ-041 random valid/ready toggling, 3 back-to-back frames -> 36 beats in order, 9 TLAST, 3 TUSER, 3 done pulses.

Source files
------------

// File: rtl/gb_pkg.sv
// rtl/gb_pkg.sv - shared types and defaults for the Gaussian output framer
package gb_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int IMG_W_DEF = 480;
    localparam int IMG_H_DEF = 640;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } gb_state_t;

    // One FIFO slot at the default pixel width. The FIFO itself is width
    // generic and stores {data, last, user} in this same bit order.
    typedef struct packed {
        logic [PIX_W_DEF-1:0] data;
        logic                 last;
        logic                 user;
    } gb_entry_t;

endpackage

// File: rtl/gb_axis_fifo2.sv
// rtl/gb_axis_fifo2.sv - two-entry stream FIFO holding {data, last, user}
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wr_data     write strobe and entry (ignored while full)
//   pop               read strobe (ignored while empty)
//   rd_data           head entry, valid while ~empty
//   full, empty       occupancy flags
module gb_axis_fifo2 #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gb_out_framer.sv
// rtl/gb_out_framer.sv - frames one image of filtered pixels with TLAST/TUSER
//
// Ports:
//   ap_clk, ap_rst_n                 clock, asynchronous active-low reset
//   start                            pulse arming one frame (ignored while busy)
//   in_TDATA/in_TVALID/in_TREADY     upstream pixel stream
//   out_TDATA/TVALID/TREADY/TLAST/TUSER  downstream framed stream
//   busy                             frame in progress
//   done                             one-cycle pulse once the frame has left
module gb_out_framer
    import gb_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             start,
    input  logic [PIX_W-1:0] in_TDATA,
    input  logic             in_TVALID,
    output logic             in_TREADY,
    output logic [PIX_W-1:0] out_TDATA,
    output logic             out_TVALID,
    input  logic             out_TREADY,
    output logic             out_TLAST,
    output logic             out_TUSER,
    output logic             busy,
    output logic             done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    gb_state_t       state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic            fifo_full;
    logic            fifo_empty;
    logic            accept;
    logic            pop;
    logic [PIX_W+1:0] wr_entry;
    logic [PIX_W+1:0] rd_entry;

    assign in_TREADY = (state == ST_RUN) & ~fifo_full;
    assign accept    = in_TVALID & in_TREADY;
    assign out_TVALID = ~fifo_empty;
    assign pop       = out_TVALID & out_TREADY;

    assign wr_entry = {in_TDATA, (x == X_LAST), ((x == '0) && (y == '0))};
    assign {out_TDATA, out_TLAST, out_TUSER} = rd_entry;

    gb_axis_fifo2 #(
        .W(PIX_W + 2)
    ) u_fifo (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .push    (accept),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= ST_IDLE;
            x     <= '0;
            y     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        x     <= '0;
                        y     <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (x == X_LAST) begin
                            x <= '0;
                            // Final pixel: y is left at its last value so the
                            // counter never steps past IMG_H-1.
                            if (y == Y_LAST) begin
                                state <= ST_DRAIN;
                            end else begin
                                y <= y + 1'b1;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
